// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction prefetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a free queue slot
    ST_REQ  = 2'd1,  // request presented, waiting for grant
    ST_WAIT = 2'd2,  // request granted, waiting for response
    ST_DROP = 2'd3   // response in flight belongs to a squashed path
  } fetch_state_e;

  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Canonical RISC-V NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One queue entry is {pc, instr}
  localparam int unsigned ENTRY_W = 64;

  // Force an address onto a word boundary; all 32 bits are consumed on purpose
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous DEPTH x 64-bit prefetch queue with push, pop,
//                synchronous flush, and count/empty/full status.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // Overflowing pushes and underflowing pops are silently dropped
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  // Head is forced to zero when empty so no stale data leaks out
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush overrides any push/pop that cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; a write landing during a flush is harmless (pointers reset)
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_unit
//  Description : Single-outstanding instruction prefetcher. Issues word
//                fetches to instruction memory, buffers {pc, instr} in a
//                small queue toward decode, and squashes on redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // control flow change
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // toward IF/ID
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        fetch_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q, pc_d;          // next address to fetch
  logic [31:0]         req_pc_q, req_pc_d;  // address of the granted request

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [CNT_W:0]      cnt_after_push;
  logic                room_after_push;

  // Queue occupancy after a push this cycle, net of any simultaneous pop
  assign cnt_after_push  = {1'b0, fifo_count} + (CNT_W+1)'(1) - (CNT_W+1)'(fifo_pop);
  assign room_after_push = (cnt_after_push < (CNT_W+1)'(DEPTH));

  assign fifo_pop    = ~fifo_empty & fetch_ready;
  assign fetch_valid = ~fifo_empty;
  assign fetch_pc    = fifo_rdata[63:32];
  assign fetch_instr = fifo_rdata[31:0];

  // Address bus is parked at zero whenever no request is presented
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = imem_req ? pc_q : 32'h0;

  // Next-state, fetch address and queue push decisions
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    fifo_push = 1'b0;

    case (state_q)
      // Nothing is outstanding here, so a free slot is simply "not full"
      ST_IDLE: begin
        if (!fifo_full) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = room_after_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides the sequential path. A response arriving in the
    // same cycle as the redirect is already consumed, so it no longer counts
    // as in flight; waiting for it in DROP would stall forever.
    if (redirect) begin
      pc_d = word_align(redirect_pc);
      if (state_q == ST_DROP) begin
        state_d = imem_rvalid ? ST_REQ : ST_DROP;
      end else if ((state_q == ST_WAIT && !imem_rvalid) ||
                   (state_q == ST_REQ  && imem_gnt)) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // Sequencer registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({req_pc_q, imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_gnt  input  1  request accepted this cycle.
REQ-008 imem_rvalid  input  1  response data valid.
REQ-009 imem_rdata  input  32  fetched instruction.
REQ-010 redirect  input  1  taken branch or jump; flush and refetch.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 fetch_valid  output  1  queue head valid toward the IF/ID register.
REQ-013 fetch_pc  output  32  PC of the head entry.
REQ-014 fetch_instr  output  32  instruction of the head entry.
REQ-015 fetch_ready  input  1  decode accepts the head this cycle.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT, DROP.
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 IDLE SHALL go to REQ when (queue count + outstanding) < DEPTH, so every accepted request has a reserved slot.
REQ-019 REQ SHALL drive imem_req=1 with imem_addr=fetch address.
REQ-020 REQ SHALL, on imem_gnt, latch the request PC, advance the fetch address by 4 (modulo 2^32), and go to WAIT.
REQ-021 While in REQ without grant, imem_req and imem_addr SHALL stay stable, except on redirect.
REQ-022 WAIT SHALL, on imem_rvalid, push {request PC, imem_rdata} into the queue.
REQ-023 On that push, WAIT SHALL go to REQ if a slot remains after the push, else to IDLE.
REQ-024 imem_rvalid SHALL be ignored in IDLE and REQ.
REQ-025 fetch_valid SHALL equal queue not-empty; fetch_pc and fetch_instr SHALL come from the registered head entry.
REQ-026 A pop SHALL occur on fetch_valid & fetch_ready.
REQ-027 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-028 On redirect, the queue SHALL be empty in the next cycle (fetch_valid=0), regardless of any push or pop in the same cycle.
REQ-029 On redirect, the fetch address SHALL become {redirect_pc[31:2], 2'b00}.
REQ-030 On redirect, the next state SHALL be DROP if a request is in flight (state WAIT, or REQ with imem_gnt that cycle), otherwise REQ.
REQ-031 DROP SHALL discard the next imem_rvalid response and then go to REQ.
REQ-032 A redirect arriving while in DROP SHALL update the fetch address and stay in DROP.
REQ-033 Latency with zero-wait memory (grant in the REQ cycle, rvalid in the next cycle): fetch_valid SHALL rise 2 cycles after the grant.
REQ-034 Sustained throughput SHALL be one instruction per 2 cycles.

Reset
REQ-035 While rst_n=0: state=IDLE, fetch address=RESET_PC, queue empty, no request outstanding.
REQ-036 While rst_n=0: imem_req=0, imem_addr=0, fetch_valid=0, fetch_pc=0, fetch_instr=0.
REQ-037 These reset values SHALL take effect immediately on assertion, independent of clk.
REQ-038 Reset asserted mid-transaction SHALL abandon the request.
REQ-039 A stale imem_rvalid after reset release SHALL be ignored, per REQ-024.

Structure
REQ-040 A shared package fetch_pkg SHALL hold the state enum, the DEPTH and RESET_PC defaults, and the NOP constant 32'h0000_0013.
REQ-041 The queue SHALL be a sub-module fetch_fifo: synchronous, DEPTH x 64 bits, with push, pop, and a synchronous flush, and with count, empty and full outputs.

Verification
REQ-042 Release reset; memory gnt=1, rvalid next cycle, rdata=addr^32'hFFFF; fetch_ready=1 -> fetch_pc sequence 0x0, 0x4, 0x8, and each fetch_instr matches its PC; one instruction per 2 cycles.
REQ-043 Hold fetch_ready=0 -> after 4 pushes imem_req stays 0 and the head shows fetch_pc=0x0; raise fetch_ready -> pops 0x0..0xC, then the next imem_addr=0x10.
REQ-044 Hold imem_gnt=0 for 5 cycles -> imem_req=1 and imem_addr=0x0 stay constant throughout; grant in cycle 6 -> fetch_pc 0x0 appears.
REQ-045 Pulse redirect with redirect_pc=0x100 while in WAIT -> next cycle fetch_valid=0; the late rvalid data is dropped; the next imem_addr=0x100; the first fetch_pc=0x100.
REQ-046 Pulse redirect with redirect_pc=0x203 -> imem_addr=0x200.
REQ-047 Assert rst_n=0 mid-WAIT -> all outputs are 0 without a clock edge; after release the first imem_addr=RESET_PC, and a stray rvalid is ignored.
